// File: rtl/apb_slave_pkg.sv
// Shared types and constants for the APB completer register file.
//   state_e          : completer FSM states
//   WAIT_W           : width of the programmable wait-state count
//   ID_VALUE_DEFAULT : default contents of read-only register 0
package apb_slave_pkg;

    localparam int unsigned WAIT_W = 4;

    localparam logic [31:0] ID_VALUE_DEFAULT = 32'hA5B0_0001;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_e;

endpackage : apb_slave_pkg

// File: rtl/apb_slave_regbank.sv
// Register storage for the APB completer.
//   pclk, presetn : clock and synchronous active-low reset (clears all entries)
//   we, widx,     : single write port; index 0 is read-only and never written
//   wdata
//   ridx, rdata   : asynchronous read port; index 0 returns ID_VALUE
module apb_slave_regbank
    import apb_slave_pkg::*;
#(
    parameter int unsigned NUM_REGS = 16,
    parameter int unsigned DATA_W   = 32,
    parameter logic [DATA_W-1:0] ID_VALUE = DATA_W'(ID_VALUE_DEFAULT),
    localparam int unsigned IDX_W   = $clog2(NUM_REGS)
) (
    input  logic              pclk,
    input  logic              presetn,
    input  logic              we,
    input  logic [IDX_W-1:0]  widx,
    input  logic [DATA_W-1:0] wdata,
    input  logic [IDX_W-1:0]  ridx,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [NUM_REGS];

    // Storage update; entry 0 is shadowed by ID_VALUE on the read side.
    always_ff @(posedge pclk) begin
        if (!presetn) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                mem[i] <= '0;
            end
        end else if (we && (widx != '0)) begin
            mem[widx] <= wdata;
        end
    end

    // Read port; the parent masks out-of-range indices via its decode error.
    assign rdata = (ridx == '0) ? ID_VALUE : mem[ridx];

endmodule : apb_slave_regbank

// File: rtl/apb_slave_regfile.sv
// APB3 completer fronting a bank of NUM_REGS word-addressed registers.
// Inserts a programmable number of wait states per transfer and raises
// pslverr on misaligned, out-of-range, or read-only-register writes.
//   pclk, presetn  : clock and synchronous active-low reset
//   psel, penable  : APB select and access strobe
//   pwrite         : 1 = write, 0 = read
//   paddr, pwdata  : byte address and write data
//   wait_cycles    : wait states for the next transfer, sampled at setup
//   prdata         : registered read data, valid with pready on reads
//   pready         : registered transfer-complete
//   pslverr        : registered error, valid with pready
module apb_slave_regfile
    import apb_slave_pkg::*;
#(
    parameter int unsigned APB_MAX_ADDRESS_WIDTH = 16,
    parameter int unsigned APB_MAX_DATA_WIDTH    = 32,
    parameter int unsigned NUM_REGS              = 16,
    parameter logic [APB_MAX_DATA_WIDTH-1:0] ID_VALUE =
        APB_MAX_DATA_WIDTH'(ID_VALUE_DEFAULT)
) (
    input  logic                          pclk,
    input  logic                          presetn,
    input  logic                          psel,
    input  logic                          penable,
    input  logic                          pwrite,
    input  logic [APB_MAX_ADDRESS_WIDTH-1:0] paddr,
    input  logic [APB_MAX_DATA_WIDTH-1:0] pwdata,
    input  logic [WAIT_W-1:0]             wait_cycles,
    output logic [APB_MAX_DATA_WIDTH-1:0] prdata,
    output logic                          pready,
    output logic                          pslverr
);

    localparam int unsigned AW    = APB_MAX_ADDRESS_WIDTH;
    localparam int unsigned DW    = APB_MAX_DATA_WIDTH;
    localparam int unsigned IDX_W = $clog2(NUM_REGS);

    state_e             state_q, state_d;
    logic [WAIT_W-1:0]  cnt_q, cnt_d;
    logic               wr_q, wr_d;
    logic               err_q, err_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [DW-1:0]      wdata_q, wdata_d;
    logic               pready_d, pslverr_d;
    logic [DW-1:0]      prdata_d;

    logic               dec_err_c;
    logic [IDX_W-1:0]   addr_idx_c;
    logic [IDX_W-1:0]   rd_idx_c;
    logic [DW-1:0]      rdata_c;
    logic               we_c;

    // Address decode of the setup-phase request.
    always_comb begin
        addr_idx_c = paddr[IDX_W+1:2];
        dec_err_c  = (paddr[1:0] != 2'b00)
                  || (32'(paddr[AW-1:2]) >= 32'(NUM_REGS))
                  || (pwrite && (paddr[AW-1:2] == '0));
    end

    apb_slave_regbank #(
        .NUM_REGS (NUM_REGS),
        .DATA_W   (DW),
        .ID_VALUE (ID_VALUE)
    ) u_regbank (
        .pclk    (pclk),
        .presetn (presetn),
        .we      (we_c),
        .widx    (idx_q),
        .wdata   (wdata_q),
        .ridx    (rd_idx_c),
        .rdata   (rdata_c)
    );

    // State and output registers.
    always_ff @(posedge pclk) begin
        if (!presetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            pready  <= 1'b0;
            pslverr <= 1'b0;
            prdata  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            err_q   <= err_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            pready  <= pready_d;
            pslverr <= pslverr_d;
            prdata  <= prdata_d;
        end
    end

    // Next-state, wait counting, write commit and output loading.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wr_d      = wr_q;
        err_d     = err_q;
        idx_d     = idx_q;
        wdata_d   = wdata_q;
        pready_d  = pready;
        pslverr_d = pslverr;
        prdata_d  = prdata;
        we_c      = 1'b0;
        // With zero wait states the read happens at setup, before the index is latched.
        rd_idx_c  = (state_q == IDLE) ? addr_idx_c : idx_q;

        case (state_q)
            IDLE: begin
                if (psel && !penable) begin
                    state_d  = ACCESS;
                    cnt_d    = wait_cycles;
                    wr_d     = pwrite;
                    err_d    = dec_err_c;
                    idx_d    = addr_idx_c;
                    wdata_d  = pwdata;
                    pready_d = (wait_cycles == '0);
                    if (wait_cycles == '0) begin
                        pslverr_d = dec_err_c;
                        prdata_d  = (dec_err_c || pwrite) ? '0 : rdata_c;
                    end
                end
            end

            ACCESS: begin
                if (!psel) begin
                    // Master abort: drop the transfer without writing.
                    state_d   = IDLE;
                    pready_d  = 1'b0;
                    pslverr_d = 1'b0;
                    prdata_d  = '0;
                end else if (!pready) begin
                    cnt_d = cnt_q - WAIT_W'(1);
                    if (cnt_q == WAIT_W'(1)) begin
                        pready_d  = 1'b1;
                        pslverr_d = err_q;
                        prdata_d  = (err_q || wr_q) ? '0 : rdata_c;
                    end
                end else begin
                    we_c      = penable && wr_q && !err_q;
                    state_d   = IDLE;
                    pready_d  = 1'b0;
                    pslverr_d = 1'b0;
                    prdata_d  = '0;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule : apb_slave_regfile

// File: tb/tb_apb_slave_regfile.sv
module tb_apb_slave_regfile;

    localparam logic [31:0] ID = 32'hA5B0_0001;

    logic        pclk;
    logic        presetn;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [15:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  wait_cycles;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    int errors = 0;
    int checks = 0;

    logic [31:0] rd;
    logic        se;
    int          cyc;

    apb_slave_regfile dut (
        .pclk        (pclk),
        .presetn     (presetn),
        .psel        (psel),
        .penable     (penable),
        .pwrite      (pwrite),
        .paddr       (paddr),
        .pwdata      (pwdata),
        .wait_cycles (wait_cycles),
        .prdata      (prdata),
        .pready      (pready),
        .pslverr     (pslverr)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One APB transfer; ends after the negedge where pready is seen, psel still high.
    task automatic xfer(input logic wr, input logic [15:0] addr, input logic [31:0] wd,
                        input logic [3:0] w, output logic [31:0] rdat, output logic err,
                        output int ncyc);
        bit done;
        done = 1'b0;
        ncyc = 0;
        @(posedge pclk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd;
        wait_cycles = w;
        @(posedge pclk); #1;
        penable = 1'b1;
        wait_cycles = 4'd0;
        while (!done && ncyc < 40) begin
            @(negedge pclk);
            ncyc++;
            if (pready) done = 1'b1;
        end
        rdat = prdata;
        err  = pslverr;
        if (!done) check("pready_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle_bus();
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    initial begin
        presetn = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; wait_cycles = '0;

        // Reset state
        repeat (2) @(posedge pclk);
        @(negedge pclk);
        check("rst_pready", 32'(pready), 32'd0);
        check("rst_pslverr", 32'(pslverr), 32'd0);
        check("rst_prdata", prdata, 32'd0);
        @(posedge pclk); #1; presetn = 1'b1;

        // Zero-wait write then read
        xfer(1'b1, 16'h0004, 32'h1234_5678, 4'd0, rd, se, cyc);
        check("w4_cycles", 32'(cyc), 32'd1);
        check("w4_err", 32'(se), 32'd0);
        idle_bus();
        xfer(1'b0, 16'h0004, 32'h0, 4'd0, rd, se, cyc);
        check("r4_cycles", 32'(cyc), 32'd1);
        check("r4_data", rd, 32'h1234_5678);
        check("r4_err", 32'(se), 32'd0);
        idle_bus();

        // ID register with three wait states (wait_cycles changed mid-transfer)
        xfer(1'b0, 16'h0000, 32'h0, 4'd3, rd, se, cyc);
        check("r0_w3_cycles", 32'(cyc), 32'd4);
        check("r0_w3_data", rd, ID);
        check("r0_w3_err", 32'(se), 32'd0);
        idle_bus();

        // Decode errors
        xfer(1'b1, 16'h0000, 32'hDEAD_BEEF, 4'd0, rd, se, cyc);
        check("w0_err", 32'(se), 32'd1);
        idle_bus();
        xfer(1'b0, 16'h0042, 32'h0, 4'd1, rd, se, cyc);
        check("r42_cycles", 32'(cyc), 32'd2);
        check("r42_err", 32'(se), 32'd1);
        check("r42_data", rd, 32'd0);
        idle_bus();
        xfer(1'b0, 16'h0040, 32'h0, 4'd0, rd, se, cyc);
        check("r40_err", 32'(se), 32'd1);
        check("r40_data", rd, 32'd0);
        idle_bus();
        xfer(1'b0, 16'h0000, 32'h0, 4'd0, rd, se, cyc);
        check("r0_after_w0", rd, ID);
        idle_bus();

        // Back-to-back writes, no idle cycle between them
        xfer(1'b1, 16'h0008, 32'hCAFE_0008, 4'd1, rd, se, cyc);
        check("b2b_w8_cycles", 32'(cyc), 32'd2);
        xfer(1'b1, 16'h000C, 32'hBEEF_000C, 4'd2, rd, se, cyc);
        check("b2b_wc_cycles", 32'(cyc), 32'd3);
        check("b2b_wc_err", 32'(se), 32'd0);
        xfer(1'b0, 16'h0008, 32'h0, 4'd0, rd, se, cyc);
        check("b2b_r8", rd, 32'hCAFE_0008);
        xfer(1'b0, 16'h000C, 32'h0, 4'd0, rd, se, cyc);
        check("b2b_rc", rd, 32'hBEEF_000C);
        idle_bus();

        // Longest wait
        xfer(1'b0, 16'h003C, 32'h0, 4'd15, rd, se, cyc);
        check("w15_cycles", 32'(cyc), 32'd16);
        check("w15_data", rd, 32'd0);
        idle_bus();

        // Reset during the access phase of a write
        @(posedge pclk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 16'h0010;
        pwdata = 32'h5555_AAAA; wait_cycles = 4'd0;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(negedge pclk);
        check("rstx_pready_before", 32'(pready), 32'd1);
        presetn = 1'b0;
        @(negedge pclk);
        check("rstx_pready", 32'(pready), 32'd0);
        check("rstx_pslverr", 32'(pslverr), 32'd0);
        check("rstx_prdata", prdata, 32'd0);
        presetn = 1'b1; psel = 1'b0; penable = 1'b0;
        xfer(1'b0, 16'h0010, 32'h0, 4'd0, rd, se, cyc);
        check("rstx_r10", rd, 32'd0);
        xfer(1'b0, 16'h0004, 32'h0, 4'd0, rd, se, cyc);
        check("rstx_r4_cleared", rd, 32'd0);
        idle_bus();

        // Master abort during wait states
        xfer(1'b1, 16'h0014, 32'h1111_1111, 4'd0, rd, se, cyc);
        idle_bus();
        @(posedge pclk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 16'h0014;
        pwdata = 32'h2222_2222; wait_cycles = 4'd5;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(negedge pclk);
        check("abort_wait_pready", 32'(pready), 32'd0);
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge pclk);
            check("abort_no_pready", 32'(pready), 32'd0);
        end
        xfer(1'b0, 16'h0014, 32'h0, 4'd0, rd, se, cyc);
        check("abort_r14", rd, 32'h1111_1111);
        check("abort_r14_cycles", 32'(cyc), 32'd1);
        idle_bus();

        repeat (2) @(posedge pclk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_apb_slave_regfile
